snake_food_collide: RTL

- Downstream stage of the snake movement block.
- On every game tick it consumes the snake's head/body snapshot and checks the head against the food cell and every valid body segment.
- Raises the `grow` pulse that feeds back into the snake block, latches a sticky game-over, and relocates food via an LFSR to a cell not occupied by the snake.
- Sits between the snake block and the display/score logic.

---
 rtl/snake_pkg.sv | 15 +
 rtl/snake_food_collide_lfsr.sv | 17 +
 rtl/snake_food_collide.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake food/collision stage.
// Cells are {y[3:0], x[3:0]} on a 16x16 grid.
package snake_pkg;
    localparam int GRID_BITS = 4;
    localparam int SEG_W     = 2 * GRID_BITS;
    localparam int SEGS      = 25;
    localparam int MAX_TRIES = 255;

    typedef logic [SEG_W-1:0] cell_t;

    localparam cell_t FOOD_INIT = 8'h88;
    localparam cell_t LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {IDLE, EATCHK, SCAN, PLACE, DEAD} state_t;
endpackage

// File: rtl/snake_food_collide_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with the feedback bit into bit 0.
module snake_lfsr8
    import snake_pkg::*;
(
    input  logic  clk,
    input  logic  start,
    input  logic  step,
    output cell_t q
);
    always_ff @(posedge clk) begin
        if (start) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end
endmodule

// File: rtl/snake_food_collide.sv
// Per-tick head check against food and body, sticky game-over, and food relocation
// to an unoccupied cell. update is a single-cycle strobe accepted only in IDLE.
module snake_food_collide
    import snake_pkg::*;
(
    input  logic                  clk,
    input  logic                  start,
    input  logic                  update,
    input  logic [39:0]           head,
    input  logic [SEGS*SEG_W-1:0] body,
    input  logic [4:0]            body_len,
    output logic                  grow,
    output logic                  game_over,
    output cell_t                 food_pos,
    output logic [7:0]            score,
    output logic                  busy
);
    state_t     state, state_n;
    cell_t      head_q;
    cell_t      segs_q [SEGS];
    logic [4:0] len_q, idx, idx_n, sel_idx;
    logic [7:0] tries, tries_n, score_n;
    logic       eat_q, eat_n, go_n, step, cap, done;
    cell_t      food_n, cand, probe;
    logic       unused_head;

    assign unused_head = ^head[39:8];

    snake_lfsr8 u_lfsr (
        .clk   (clk),
        .start (start),
        .step  (step),
        .q     (cand)
    );

    // In PLACE, idx 0 probes the head and idx k probes segment k-1.
    always_comb begin
        sel_idx = idx;
        if (state == PLACE && idx != 5'd0) sel_idx = idx - 5'd1;
        probe = (state == PLACE && idx == 5'd0) ? head_q : segs_q[sel_idx];
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tries_n = tries;
        eat_n   = eat_q;
        food_n  = food_pos;
        score_n = score;
        go_n    = game_over;
        step    = 1'b0;
        cap     = 1'b0;
        grow    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (update) begin
                    cap     = 1'b1;
                    state_n = EATCHK;
                end
            end
            EATCHK: begin
                eat_n   = (head_q == food_pos);
                idx_n   = 5'd0;
                state_n = SCAN;
            end
            SCAN: begin
                if (len_q != 5'd0 && probe == head_q) begin
                    go_n    = 1'b1;
                    state_n = DEAD;
                end else if (len_q == 5'd0 || idx == len_q - 5'd1) begin
                    idx_n = 5'd0;
                    if (eat_q) begin
                        step    = 1'b1;
                        tries_n = 8'd0;
                        state_n = PLACE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    idx_n = idx + 5'd1;
                end
            end
            PLACE: begin
                if (probe == cand) begin
                    if (tries == 8'(MAX_TRIES - 1)) begin
                        done = 1'b1;
                    end else begin
                        tries_n = tries + 8'd1;
                        step    = 1'b1;
                        idx_n   = 5'd0;
                    end
                end else if (idx == len_q) begin
                    food_n = cand;
                    done   = 1'b1;
                end else begin
                    idx_n = idx + 5'd1;
                end
                if (done) begin
                    grow    = 1'b1;
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    idx_n   = 5'd0;
                    state_n = IDLE;
                end
            end
            DEAD: state_n = DEAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state     <= IDLE;
            food_pos  <= FOOD_INIT;
            score     <= 8'd0;
            game_over <= 1'b0;
            idx       <= 5'd0;
            tries     <= 8'd0;
            eat_q     <= 1'b0;
            head_q    <= '0;
            len_q     <= 5'd0;
        end else begin
            state     <= state_n;
            food_pos  <= food_n;
            score     <= score_n;
            game_over <= go_n;
            idx       <= idx_n;
            tries     <= tries_n;
            eat_q     <= eat_n;
            if (cap) begin
                head_q <= head[SEG_W-1:0];
                len_q  <= (body_len > 5'(SEGS)) ? 5'(SEGS) : body_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            for (int k = 0; k < SEGS; k++) segs_q[k] <= body[k*SEG_W +: SEG_W];
        end
    end

    assign busy = (state != IDLE) && (state != DEAD);
endmodule
